// File: rtl/fetch_unit_pkg.sv
// Shared pipeline constants for the Riscv151 front end and datapath selects.
// Fetch-side values live alongside the operand and writeback select encodings.
package fetch_unit_pkg;

   localparam int XLEN = 32;

   localparam logic [1:0] PCSEL_PLUS4 = 2'd0;
   localparam logic [1:0] PCSEL_ALU   = 2'd1;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;
   localparam logic [31:0] RESET_PC = 32'h0000_2000;

   localparam logic       ASEL_REG  = 1'b0;
   localparam logic       ASEL_PC   = 1'b1;
   localparam logic       BSEL_REG  = 1'b0;
   localparam logic       BSEL_IMM  = 1'b1;
   localparam logic [1:0] WBSEL_MEM = 2'd0;
   localparam logic [1:0] WBSEL_ALU = 2'd1;
   localparam logic [1:0] WBSEL_PC4 = 2'd2;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
      return {a[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-to-ICache request/response handshake, one request outstanding at a time.
interface fetch_unit_if #(parameter int WIDTH = 32);

   logic             icache_re;
   logic [WIDTH-1:0] icache_addr;
   logic             icache_ready;
   logic             icache_valid;
   logic [31:0]      icache_dout;

   modport master (
      output icache_re, icache_addr,
      input  icache_ready, icache_valid, icache_dout
   );

   modport slave (
      input  icache_re, icache_addr,
      output icache_ready, icache_valid, icache_dout
   );

endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry skid register that parks an ICache response arriving while the I-stage is stalled.
module fetch_hold_buf #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic         clear,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full
);

   logic         full_q, full_d;
   logic [W-1:0] data_q, data_d;

   // Clear beats push so a redirect always discards wrong-path data.
   always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (clear) begin
         full_d = 1'b0;
      end else if (push) begin
         full_d = 1'b1;
         data_d = din;
      end else if (pop) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end

   assign dout = data_q;
   assign full = full_q;

endmodule

// File: rtl/fetch_unit.sv
// I-stage fetch front end: owns the fetch PC, runs the ICache handshake and
// presents the fetched instruction (or a NOP bubble) to the decoder.
module fetch_unit #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = fetch_unit_pkg::RESET_PC,
   parameter logic [31:0]      NOP_INST = fetch_unit_pkg::NOP_INST
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         PC_Sel,
   input  logic [WIDTH-1:0]   ALU_Out,
   input  logic               Stall,
   fetch_unit_if.master       icache,
   output logic [31:0]        inst,
   output logic               inst_valid,
   output logic [WIDTH-1:0]   PC_I,
   output logic [WIDTH-1:0]   PC_X
);

   import fetch_unit_pkg::*;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] pc_fetch_q, pc_fetch_d;
   logic [WIDTH-1:0] pc_i_q, pc_i_d;
   logic [WIDTH-1:0] pc_x_q, pc_x_d;
   logic [31:0]      inst_q, inst_d;
   logic             inst_valid_q, inst_valid_d;

   logic             redirect, rsp_valid, b2b, req_fire;
   logic             hold_full, hold_push, hold_pop;
   logic [31:0]      hold_dout;
   logic [WIDTH-1:0] pc_plus4, target;
   logic             unused_alu_lsb;

   assign redirect  = (PC_Sel == PCSEL_ALU);
   assign rsp_valid = icache.icache_valid;
   assign pc_plus4  = pc_fetch_q + WIDTH'(4);
   assign target    = {ALU_Out[WIDTH-1:2], 2'b00};
   assign unused_alu_lsb = ^ALU_Out[1:0];

   // Back-to-back: a response delivered this cycle immediately launches the next fetch.
   assign b2b = (state_q == S_WAIT) && rsp_valid && !Stall && !redirect && !hold_full;

   assign icache.icache_re   = reset && (((state_q == S_REQ) && !hold_full) || b2b);
   assign icache.icache_addr = b2b ? pc_plus4 : pc_fetch_q;
   assign req_fire           = icache.icache_re && icache.icache_ready;

   assign hold_push = (state_q == S_WAIT) && rsp_valid && Stall && !redirect;
   assign hold_pop  = hold_full && !Stall && !redirect;

   fetch_hold_buf #(.W(32)) u_hold (
      .clk   (clk),
      .reset (reset),
      .push  (hold_push),
      .pop   (hold_pop),
      .clear (redirect),
      .din   (icache.icache_dout),
      .dout  (hold_dout),
      .full  (hold_full)
   );

   always_comb begin
      state_d      = state_q;
      pc_fetch_d   = pc_fetch_q;
      inst_d       = inst_q;
      inst_valid_d = inst_valid_q;
      pc_i_d       = pc_i_q;
      pc_x_d       = pc_x_q;

      if (redirect) begin
         pc_fetch_d   = target;
         inst_d       = NOP_INST;
         inst_valid_d = 1'b0;
         pc_x_d       = pc_i_q;
         // A request accepted this very cycle still owes a response, so it must be dropped.
         case (state_q)
            S_REQ:   state_d = req_fire ? S_DROP : S_REQ;
            default: state_d = rsp_valid ? S_REQ : S_DROP;
         endcase
      end else if (Stall) begin
         case (state_q)
            S_REQ:   if (req_fire)  state_d = S_WAIT;
            S_WAIT:  if (rsp_valid) state_d = S_REQ;
            default: if (rsp_valid) state_d = S_REQ;
         endcase
      end else begin
         pc_x_d       = pc_i_q;
         inst_d       = NOP_INST;
         inst_valid_d = 1'b0;
         case (state_q)
            S_REQ: begin
               // Drain the parked response; pc_fetch still names it since it never advanced.
               if (hold_full) begin
                  inst_d       = hold_dout;
                  inst_valid_d = 1'b1;
                  pc_i_d       = pc_fetch_q;
                  pc_fetch_d   = pc_plus4;
               end
               if (req_fire) state_d = S_WAIT;
            end
            S_WAIT: begin
               if (rsp_valid) begin
                  inst_d       = icache.icache_dout;
                  inst_valid_d = 1'b1;
                  pc_i_d       = pc_fetch_q;
                  pc_fetch_d   = pc_plus4;
                  state_d      = req_fire ? S_WAIT : S_REQ;
               end
            end
            default: if (rsp_valid) state_d = S_REQ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= S_REQ;
         pc_fetch_q   <= RESET_PC;
         inst_q       <= NOP_INST;
         inst_valid_q <= 1'b0;
         pc_i_q       <= '0;
         pc_x_q       <= '0;
      end else begin
         state_q      <= state_d;
         pc_fetch_q   <= pc_fetch_d;
         inst_q       <= inst_d;
         inst_valid_q <= inst_valid_d;
         pc_i_q       <= pc_i_d;
         pc_x_q       <= pc_x_d;
      end
   end

   assign inst       = inst_q;
   assign inst_valid = inst_valid_q;
   assign PC_I       = pc_i_q;
   assign PC_X       = pc_x_q;

endmodule
